// File: rtl/add_accum.sv
// Streaming accumulator: sums a counted burst of operand words (with optional
// carry-in on the first word) and hands the sum, last carry and sticky overflow downstream.
module add_accum #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_cin,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DW-1:0]    o_sum,
  output logic             o_c,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cin_r;
  logic             first;
  logic             beat;
  logic             last_beat;
  logic [DW:0]      add_res;

  // Handshake flags decode straight from the state register, never from inputs.
  assign o_ready = (state == ACC);
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);

  assign beat      = i_valid & o_ready;
  assign last_beat = beat & (cnt == CNT_W'(1));

  // Same a + b + c function as the downstream carry-lookahead adder; bit DW is the carry-out.
  assign add_res = {1'b0, o_sum} + {1'b0, i_data} + (DW+1)'(first & cin_r);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = (i_len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sum <= '0;
      o_c   <= 1'b0;
      o_ovf <= 1'b0;
      cnt   <= '0;
      cin_r <= 1'b0;
      first <= 1'b0;
    end else begin
      if (state == IDLE && i_start) begin
        // A zero-length burst goes straight to DONE with a clean zero result.
        o_sum <= '0;
        o_c   <= 1'b0;
        o_ovf <= 1'b0;
        if (i_len != '0) begin
          cnt   <= i_len;
          cin_r <= i_cin;
          first <= 1'b1;
        end
      end else if (beat) begin
        o_sum <= add_res[DW-1:0];
        o_ovf <= o_ovf | add_res[DW];
        cnt   <= cnt - CNT_W'(1);
        first <= 1'b0;
        if (last_beat) begin
          o_c <= add_res[DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_add_accum.sv
// Directed bench for add_accum: a table of bursts with hand-computed results,
// plus hand-written sequences for bubbles/backpressure and mid-burst reset.
module tb_add_accum;

  localparam int DW    = 32;
  localparam int CNT_W = 8;
  localparam int NVEC  = 8;

  typedef struct packed {
    logic [CNT_W-1:0]    len;
    logic                cin;
    logic [7:0][DW-1:0]  data;
    logic [DW-1:0]       exp_sum;
    logic                exp_c;
    logic                exp_ovf;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_len = '0;
  logic             i_cin = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [DW-1:0]    i_data = '0;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [DW-1:0]    o_sum;
  logic             o_c;
  logic             o_ovf;
  logic             o_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  vec_t vecs [NVEC];

  add_accum #(.DW(DW), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_cin   (i_cin),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_c     (o_c),
    .o_ovf   (o_ovf),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  // Start a burst, feed words back-to-back with i_ready high, check latency and result.
  task automatic run_vec(input vec_t v, input string tag);
    i_ready = 1'b1;
    i_start = 1'b1;
    i_len   = v.len;
    i_cin   = v.cin;
    i_valid = 1'b0;
    cyc     = 0;
    tick();
    i_start = 1'b0;
    i_cin   = 1'b0;
    for (int k = 0; k < int'(v.len); k++) begin
      check({tag, " ready"}, 64'(o_ready), 64'd1);
      check({tag, " early_valid"}, 64'(o_valid), 64'd0);
      i_valid = 1'b1;
      i_data  = v.data[k];
      tick();
    end
    i_valid = 1'b0;
    i_data  = '0;
    check({tag, " valid_at_len+1"}, 64'(o_valid), 64'd1);
    check({tag, " ready_in_done"}, 64'(o_ready), 64'd0);
    check({tag, " sum"}, 64'(o_sum), 64'(v.exp_sum));
    check({tag, " c"}, 64'(o_c), 64'(v.exp_c));
    check({tag, " ovf"}, 64'(o_ovf), 64'(v.exp_ovf));
    tick();
    check({tag, " idle_after"}, 64'(o_busy), 64'd0);
    check({tag, " valid_fell"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{len: 8'd3, cin: 1'b1, data: {160'd0, 32'd3, 32'd2, 32'd1},
                exp_sum: 32'd7, exp_c: 1'b0, exp_ovf: 1'b0};
    // Second addition carries out, so the last carry is 1 as well as the sticky flag.
    vecs[1] = '{len: 8'd2, cin: 1'b0, data: {192'd0, 32'h0000_0002, 32'hFFFF_FFFF},
                exp_sum: 32'h0000_0001, exp_c: 1'b1, exp_ovf: 1'b1};
    vecs[2] = '{len: 8'd3, cin: 1'b0, data: {160'd0, 32'h0, 32'h0000_0002, 32'hFFFF_FFFF},
                exp_sum: 32'h0000_0001, exp_c: 1'b0, exp_ovf: 1'b1};
    vecs[3] = '{len: 8'd1, cin: 1'b1, data: {224'd0, 32'hFFFF_FFFF},
                exp_sum: 32'h0, exp_c: 1'b1, exp_ovf: 1'b1};
    vecs[4] = '{len: 8'd0, cin: 1'b1, data: '0,
                exp_sum: 32'h0, exp_c: 1'b0, exp_ovf: 1'b0};
    vecs[5] = '{len: 8'd2, cin: 1'b1, data: {192'd0, 32'h0, 32'hFFFF_FFFE},
                exp_sum: 32'hFFFF_FFFF, exp_c: 1'b0, exp_ovf: 1'b0};
    vecs[6] = '{len: 8'd4, cin: 1'b0,
                data: {128'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
                exp_sum: 32'h0, exp_c: 1'b1, exp_ovf: 1'b1};
    vecs[7] = '{len: 8'd8, cin: 1'b1,
                data: {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1},
                exp_sum: 32'd37, exp_c: 1'b0, exp_ovf: 1'b0};

    // Reset values.
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst ready", 64'(o_ready), 64'd0);
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst sum", 64'(o_sum), 64'd0);
    check("rst c", 64'(o_c), 64'd0);
    check("rst ovf", 64'(o_ovf), 64'd0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Bubbles, ignored starts while busy, and downstream backpressure.
    begin
      logic [3:0][DW-1:0] words;
      int  accepted;
      bit  tog;
      bit  done;
      words    = {32'd40, 32'd30, 32'd20, 32'd10};
      accepted = 0;
      tog      = 1'b1;
      done     = 1'b0;
      i_ready  = 1'b0;
      i_start  = 1'b1;
      i_len    = 8'd4;
      i_cin    = 1'b0;
      cyc      = 0;
      tick();
      for (int t = 0; t < 40; t++) begin
        if (o_valid) begin
          done = 1'b1;
          break;
        end
        i_start = 1'b1;
        i_len   = 8'd1;
        i_valid = tog;
        i_data  = (tog && accepted < 4) ? words[accepted] : 32'hDEAD_BEEF;
        if (tog && o_ready) accepted++;
        tog = ~tog;
        tick();
      end
      i_valid = 1'b0;
      i_start = 1'b0;
      check("bub reached_done", 64'(done), 64'd1);
      check("bub words_consumed", 64'(accepted), 64'd4);
      check("bub latency", 64'(cyc), 64'd8);
      check("bub sum", 64'(o_sum), 64'd100);
      for (int t = 0; t < 5; t++) begin
        i_start = t[0];
        tick();
        check("bp valid_held", 64'(o_valid), 64'd1);
        check("bp sum_held", 64'(o_sum), 64'd100);
      end
      // Start issued in the handoff cycle must be ignored.
      i_ready = 1'b1;
      i_start = 1'b1;
      i_len   = 8'd1;
      tick();
      i_start = 1'b0;
      check("bp idle_after_ready", 64'(o_busy), 64'd0);
      check("bp valid_fell", 64'(o_valid), 64'd0);
      check("bp sum_kept_in_idle", 64'(o_sum), 64'd100);
      tick();
      check("bp handoff_start_ignored", 64'(o_busy), 64'd0);
    end

    // Asynchronous reset mid-burst, then a fresh burst with no residue.
    begin
      vec_t fresh;
      i_start = 1'b1;
      i_len   = 8'd5;
      i_cin   = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        i_valid = 1'b1;
        i_data  = 32'h1000 + 32'(k);
        tick();
      end
      i_data = 32'h5555;
      i_rst  = 1'b1;
      #1;
      check("arst ready", 64'(o_ready), 64'd0);
      check("arst valid", 64'(o_valid), 64'd0);
      check("arst busy", 64'(o_busy), 64'd0);
      check("arst sum", 64'(o_sum), 64'd0);
      check("arst c", 64'(o_c), 64'd0);
      check("arst ovf", 64'(o_ovf), 64'd0);
      tick();
      i_rst   = 1'b0;
      i_valid = 1'b0;
      tick();
      check("arst stays_idle", 64'(o_busy), 64'd0);
      fresh = '{len: 8'd1, cin: 1'b0, data: {224'd0, 32'd9},
                exp_sum: 32'd9, exp_c: 1'b0, exp_ovf: 1'b0};
      run_vec(fresh, "post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
